// File: rtl/gm_flush_streamer.sv
// rtl/gm_flush_streamer.sv - copies the game-state RAM into the pixel generator's graphics memory during retrace
//
// On each rising edge of request, reads all CELLS cells in address order and
// writes one encoded 4-bit tile per cycle on GMaddress/GMdata.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   request    high during vertical retrace; a rising edge starts a flush
//   st_addr    game-state RAM read address
//   st_rd      game-state RAM read strobe (data returns one cycle later)
//   st_data    cell state {revealed, flagged, mine, unused, count[3:0]}
//   GMaddress  graphics-memory write address
//   GMdata     encoded tile code
//   busy       flush in progress
//   done       one-cycle pulse with the write of the last cell
//   overrun    sticky; request fell before a flush completed
module gm_flush_streamer #(
    parameter int CELLS  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              request,
    output logic [ADDR_W-1:0] st_addr,
    output logic              st_rd,
    input  logic [7:0]        st_data,
    output logic [ADDR_W-1:0] GMaddress,
    output logic [3:0]        GMdata,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic              req_q;
    logic              p1_valid;
    logic [ADDR_W-1:0] p1_addr;
    logic [3:0]        tile;
    logic              unused_bits;

    // Bit 4 of the cell state carries no display information.
    assign unused_bits = st_data[4];

    // Tile encoding; counts of 0, 8 and anything above 8 all show as blank.
    always_comb begin
        tile = 4'h0;
        if (!st_data[7]) begin
            tile = st_data[6] ? 4'h1 : 4'h0;
        end else if (st_data[5]) begin
            tile = 4'hF;
        end else if (st_data[3:0] >= 4'd1 && st_data[3:0] <= 4'd7) begin
            tile = {1'b1, st_data[2:0]};
        end else begin
            tile = 4'h8;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            st_addr   <= '0;
            st_rd     <= 1'b0;
            p1_valid  <= 1'b0;
            p1_addr   <= '0;
            GMaddress <= '0;
            GMdata    <= 4'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            req_q <= request;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (request && !req_q) begin
                        state    <= RUN;
                        st_rd    <= 1'b1;
                        st_addr  <= '0;
                        busy     <= 1'b1;
                        p1_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (done) begin
                        // Last cell was written last cycle.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!request) begin
                        // Retrace ended early: drop the pipeline and flag it.
                        state    <= IDLE;
                        st_rd    <= 1'b0;
                        busy     <= 1'b0;
                        overrun  <= 1'b1;
                        p1_valid <= 1'b0;
                    end else begin
                        // Address counter saturates; the read strobe ends after LAST.
                        if (st_addr != LAST) begin
                            st_addr <= st_addr + 1'b1;
                        end else begin
                            st_rd <= 1'b0;
                        end
                        // p1 lines up with the RAM data returned for last cycle's read.
                        p1_valid <= st_rd;
                        p1_addr  <= st_addr;
                        if (p1_valid) begin
                            GMaddress <= p1_addr;
                            GMdata    <= tile;
                            if (p1_addr == LAST) begin
                                done <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
